arr_stream_buf: RTL and testbench

//  Parametrised register-array buffer: WIDTH x DEPTH entries written by index, then

---
 rtl/arr_stream_buf.sv | 117 +++++++++++
 tb/tb_arr_stream_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arr_stream_buf.sv
// Register-array buffer: entries written by index, then streamed out in index
// order on a valid/ready interface, with programmable length and loop mode.
module arr_stream_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             g_rst,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             emit,
    input  logic [IDX_W:0]   len,
    input  logic             loop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   ONE     = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX0    = '0;

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [IDX_W:0]   ptr;
    logic [IDX_W:0]   eff_len;
    logic             loop_r;
    logic [IDX_W:0]   start_len;
    logic             wr_ok;

    assign start_len = (len > DEPTH_L) ? DEPTH_L : len;
    assign wr_ok     = ({1'b0, wr_index} < DEPTH_L);

    // ptr always names the next entry to load; reads use the pre-write array
    // contents, so a same-cycle write to the entry being read returns old data.
    always_ff @(posedge clk) begin
        if (g_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ptr       <= '0;
            eff_len   <= '0;
            loop_r    <= 1'b0;
        end else if (rst) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ptr       <= '0;
            eff_len   <= '0;
            loop_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_valid && wr_ok) begin
                mem[wr_index] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (emit) begin
                        eff_len <= start_len;
                        loop_r  <= loop;
                        if (start_len != '0) begin
                            state     <= STREAM;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_data  <= mem[IDX0];
                            ptr       <= ONE;
                            out_last  <= (start_len == ONE);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Beat held stable until accepted; a loop pass wraps with no gap.
                    if (out_valid && out_ready) begin
                        if (ptr < eff_len) begin
                            out_data <= mem[ptr[IDX_W-1:0]];
                            ptr      <= ptr + ONE;
                            out_last <= (ptr == eff_len - ONE);
                        end else if (loop_r) begin
                            out_data <= mem[IDX0];
                            ptr      <= ONE;
                            out_last <= (eff_len == ONE);
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            ptr       <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arr_stream_buf.sv
// Self-checking bench for arr_stream_buf: directed scenarios with literal
// expectations plus randomized traffic, all checked against a beat-level model.
module tb_arr_stream_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             g_rst = 1'b0;
    logic             rst = 1'b0;
    logic             wr_valid = 1'b0;
    logic [IDX_W-1:0] wr_index = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             emit = 1'b0;
    logic [IDX_W:0]   len = '0;
    logic             loop = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;

    int num_checks = 0;
    int num_errors = 0;
    bit check_en = 1'b0;

    arr_stream_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .g_rst(g_rst), .rst(rst),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data),
        .emit(emit), .len(len), .loop(loop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Beat-level model: k is the position within the current pass, data is
    // the array content captured when that beat was launched.
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] e_data = '0;
    bit e_valid = 0, e_last = 0, e_busy = 0, e_done = 0;
    bit m_act = 0, m_loop = 0;
    int m_k = 0, m_len = 0;

    always @(posedge clk) begin
        if (g_rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_act = 0; e_done = 0; e_data = '0;
        end else if (rst) begin
            m_act = 0; e_done = 0; e_data = '0;
        end else begin
            e_done = 0;
            if (!m_act) begin
                if (emit) begin
                    m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    m_loop = loop;
                    if (m_len == 0) e_done = 1;
                    else begin m_act = 1; m_k = 0; e_data = m_mem[0]; end
                end
            end else if (out_ready) begin
                if (m_k + 1 < m_len) begin m_k++; e_data = m_mem[m_k]; end
                else if (m_loop) begin m_k = 0; e_data = m_mem[0]; end
                else begin m_act = 0; e_data = '0; e_done = 1; end
            end
            if (wr_valid && int'(wr_index) < DEPTH) m_mem[wr_index] = wr_data;
        end
        e_valid = m_act;
        e_busy  = m_act;
        e_last  = m_act && (m_k == m_len - 1);
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model out_valid", out_valid, e_valid);
            checkOutput("model out_data", out_data, e_data);
            checkOutput("model out_last", out_last, e_last);
            checkOutput("model busy", busy, e_busy);
            checkOutput("model done", done, e_done);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit em, input int l, input bit lp, input bit rdy);
        emit = em; len = (IDX_W+1)'(l); loop = lp; out_ready = rdy;
        tick();
        emit = 1'b0;
    endtask

    initial begin
        int beats;
        tick();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        check_en = 1'b1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);

        // Scenario 1: fill and stream a full pass
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_index = IDX_W'(i); wr_data = 32'hA0 + i;
            tick();
        end
        wr_valid = 1'b0;
        applyStimulus(1, 4, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s1 beat data", out_data, 32'hA0 + i);
            checkOutput("s1 last", out_last, (i == 3) ? 1 : 0);
            tick();
        end
        checkOutput("s1 done", done, 1);
        checkOutput("s1 busy", busy, 0);
        tick();

        // Scenario 2: back-pressure on beat 0
        applyStimulus(1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s2 held data", out_data, 32'hA0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        checkOutput("s2 beat1", out_data, 32'hA1);
        tick();
        checkOutput("s2 done", done, 1);

        // Scenario 3: loop mode, then partial reset keeps storage
        applyStimulus(1, 3, 1, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("s3 loop data", out_data, 32'hA0 + (i % 3));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("s3 rst valid", out_valid, 0);
        applyStimulus(1, 4, 0, 1);
        checkOutput("s3 storage kept", out_data, 32'hA0);
        for (int i = 0; i < 5; i++) tick();

        // Scenario 4: write to the entry being read returns old data
        applyStimulus(1, 4, 0, 1);
        tick();
        wr_valid = 1'b1; wr_index = 2'd2; wr_data = 32'hDEAD;
        tick();
        wr_valid = 1'b0;
        checkOutput("s4 old value", out_data, 32'hA2);
        tick();
        tick();
        applyStimulus(1, 4, 0, 1);
        tick();
        tick();
        checkOutput("s4 new value", out_data, 32'hDEAD);
        tick();
        tick();

        // Scenario 5: zero length and over-length
        applyStimulus(1, 0, 0, 1);
        checkOutput("s5 len0 valid", out_valid, 0);
        checkOutput("s5 len0 done", done, 1);
        tick();
        applyStimulus(1, 7, 0, 1);
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) beats++;
            tick();
        end
        checkOutput("s5 clamp beats", beats, 4);

        // Scenario 6: global reset mid-stream clears storage
        applyStimulus(1, 4, 0, 1);
        tick();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        checkOutput("s6 valid", out_valid, 0);
        checkOutput("s6 data", out_data, 0);
        applyStimulus(1, 4, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s6 zero beat valid", out_valid, 1);
            checkOutput("s6 zero beat data", out_data, 0);
            tick();
        end
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            wr_valid  = ($urandom_range(0, 9) < 3);
            wr_index  = IDX_W'($urandom_range(0, DEPTH - 1));
            wr_data   = $urandom;
            emit      = ($urandom_range(0, 9) < 2);
            len       = (IDX_W+1)'($urandom_range(0, 7));
            loop      = ($urandom_range(0, 9) < 2);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) < 2);
            g_rst     = ($urandom_range(0, 199) < 1);
            tick();
        end
        wr_valid = 1'b0; emit = 1'b0; rst = 1'b0; g_rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
